// File: rtl/tft_ili9341_rx.sv
// Display-side receiver for the ILI9341 4-wire SPI link: oversampled byte capture,
// command decode, CASET/PASET window tracking and RAMWR to RGB565 pixel conversion.
module tft_ili9341_rx #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tft_sck,
  input  logic        tft_sdi,
  input  logic        tft_dc,
  input  logic        tft_cs,
  input  logic        tft_reset,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        param_valid,
  output logic [7:0]  param_byte,
  output logic        pixel_valid,
  output logic [8:0]  pixel_x,
  output logic [8:0]  pixel_y,
  output logic [15:0] pixel_data,
  output logic        sleep_out,
  output logic        display_on
);

  localparam logic [8:0] COL_END_RST  = 9'(WIDTH - 1);
  localparam logic [8:0] PAGE_END_RST = 9'(HEIGHT - 1);

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPIN   = 8'h10;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_RAMWRC  = 8'h3C;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CASET = 3'd1,
    ST_PASET = 3'd2,
    ST_RAMWR = 3'd3,
    ST_SKIP  = 3'd4
  } state_t;

  logic [1:0] sck_pipe_r, sdi_pipe_r, dc_pipe_r, cs_pipe_r, rstn_pipe_r;
  logic       sck_prev_r;
  logic       clear_s, rise_s;

  logic [6:0] shift_r;
  logic [2:0] bit_cnt_r;
  logic       word_valid_r, word_dc_r;
  logic [7:0] word_byte_r;

  state_t      state_r, state_nxt_s;
  logic [2:0]  param_cnt_r, param_cnt_nxt_s;
  logic        param_hi_r, param_hi_nxt_s;
  logic [8:0]  col_start_r, col_start_nxt_s, col_end_r, col_end_nxt_s;
  logic [8:0]  page_start_r, page_start_nxt_s, page_end_r, page_end_nxt_s;
  logic [8:0]  ptr_x_r, ptr_x_nxt_s, ptr_y_r, ptr_y_nxt_s;
  logic        lo_phase_r, lo_phase_nxt_s;
  logic [7:0]  hi_byte_r, hi_byte_nxt_s;
  logic        cmd_valid_r, cmd_valid_nxt_s;
  logic [7:0]  cmd_byte_r, cmd_byte_nxt_s;
  logic        param_valid_r, param_valid_nxt_s;
  logic [7:0]  param_byte_r, param_byte_nxt_s;
  logic        pixel_valid_r, pixel_valid_nxt_s;
  logic [8:0]  pixel_x_r, pixel_x_nxt_s, pixel_y_r, pixel_y_nxt_s;
  logic [15:0] pixel_data_r, pixel_data_nxt_s;
  logic        sleep_r, sleep_nxt_s, disp_r, disp_nxt_s;

  // Two-flop synchronizers for all asynchronous panel inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_pipe_r  <= 2'b00;
      sdi_pipe_r  <= 2'b00;
      dc_pipe_r   <= 2'b00;
      cs_pipe_r   <= 2'b11;
      rstn_pipe_r <= 2'b11;
      sck_prev_r  <= 1'b0;
    end else begin
      sck_pipe_r  <= {sck_pipe_r[0], tft_sck};
      sdi_pipe_r  <= {sdi_pipe_r[0], tft_sdi};
      dc_pipe_r   <= {dc_pipe_r[0], tft_dc};
      cs_pipe_r   <= {cs_pipe_r[0], tft_cs};
      rstn_pipe_r <= {rstn_pipe_r[0], tft_reset};
      sck_prev_r  <= sck_pipe_r[1];
    end
  end

  assign clear_s = reset | ~rstn_pipe_r[1];
  assign rise_s  = sck_pipe_r[1] & ~sck_prev_r;

  // Byte assembly; the counter wraps to zero on the eighth edge
  always_ff @(posedge clk) begin
    if (clear_s) begin
      shift_r      <= 7'd0;
      bit_cnt_r    <= 3'd0;
      word_valid_r <= 1'b0;
      word_dc_r    <= 1'b0;
      word_byte_r  <= 8'd0;
    end else begin
      word_valid_r <= 1'b0;
      if (cs_pipe_r[1]) begin
        bit_cnt_r <= 3'd0;
      end else if (rise_s) begin
        shift_r   <= {shift_r[5:0], sdi_pipe_r[1]};
        bit_cnt_r <= bit_cnt_r + 3'd1;
        if (bit_cnt_r == 3'd7) begin
          word_valid_r <= 1'b1;
          word_dc_r    <= dc_pipe_r[1];
          word_byte_r  <= {shift_r, sdi_pipe_r[1]};
        end else begin
          word_valid_r <= 1'b0;
        end
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
    end
  end

  // Command decoder next-state and output logic
  always_comb begin
    state_nxt_s       = state_r;
    param_cnt_nxt_s   = param_cnt_r;
    param_hi_nxt_s    = param_hi_r;
    col_start_nxt_s   = col_start_r;
    col_end_nxt_s     = col_end_r;
    page_start_nxt_s  = page_start_r;
    page_end_nxt_s    = page_end_r;
    ptr_x_nxt_s       = ptr_x_r;
    ptr_y_nxt_s       = ptr_y_r;
    lo_phase_nxt_s    = lo_phase_r;
    hi_byte_nxt_s     = hi_byte_r;
    cmd_valid_nxt_s   = 1'b0;
    cmd_byte_nxt_s    = cmd_byte_r;
    param_valid_nxt_s = 1'b0;
    param_byte_nxt_s  = param_byte_r;
    pixel_valid_nxt_s = 1'b0;
    pixel_x_nxt_s     = pixel_x_r;
    pixel_y_nxt_s     = pixel_y_r;
    pixel_data_nxt_s  = pixel_data_r;
    sleep_nxt_s       = sleep_r;
    disp_nxt_s        = disp_r;
    if (word_valid_r && !word_dc_r) begin
      cmd_valid_nxt_s = 1'b1;
      cmd_byte_nxt_s  = word_byte_r;
      lo_phase_nxt_s  = 1'b0;
      param_cnt_nxt_s = 3'd0;
      case (word_byte_r)
        CMD_SWRESET: begin
          state_nxt_s      = ST_IDLE;
          param_hi_nxt_s   = 1'b0;
          col_start_nxt_s  = 9'd0;
          col_end_nxt_s    = COL_END_RST;
          page_start_nxt_s = 9'd0;
          page_end_nxt_s   = PAGE_END_RST;
          ptr_x_nxt_s      = 9'd0;
          ptr_y_nxt_s      = 9'd0;
          hi_byte_nxt_s    = 8'd0;
          param_byte_nxt_s = 8'd0;
          pixel_x_nxt_s    = 9'd0;
          pixel_y_nxt_s    = 9'd0;
          pixel_data_nxt_s = 16'd0;
          sleep_nxt_s      = 1'b0;
          disp_nxt_s       = 1'b0;
        end
        CMD_CASET:  state_nxt_s = ST_CASET;
        CMD_PASET:  state_nxt_s = ST_PASET;
        CMD_RAMWR: begin
          state_nxt_s = ST_RAMWR;
          ptr_x_nxt_s = col_start_r;
          ptr_y_nxt_s = page_start_r;
        end
        CMD_RAMWRC: state_nxt_s = ST_RAMWR;
        CMD_SLPOUT: begin
          sleep_nxt_s = 1'b1;
          state_nxt_s = ST_SKIP;
        end
        CMD_SLPIN: begin
          sleep_nxt_s = 1'b0;
          state_nxt_s = ST_SKIP;
        end
        CMD_DISPON: begin
          disp_nxt_s  = 1'b1;
          state_nxt_s = ST_SKIP;
        end
        CMD_DISPOFF: begin
          disp_nxt_s  = 1'b0;
          state_nxt_s = ST_SKIP;
        end
        default: state_nxt_s = ST_SKIP;
      endcase
    end else if (word_valid_r) begin
      case (state_r)
        ST_CASET, ST_PASET: begin
          param_valid_nxt_s = 1'b1;
          param_byte_nxt_s  = word_byte_r;
          if (param_cnt_r != 3'd4) begin
            param_cnt_nxt_s = param_cnt_r + 3'd1;
          end else begin
            param_cnt_nxt_s = param_cnt_r;
          end
          // Only bit 0 of each high byte survives into the 9-bit coordinate
          case (param_cnt_r)
            3'd0, 3'd2: param_hi_nxt_s = word_byte_r[0];
            3'd1: begin
              if (state_r == ST_CASET) begin
                col_start_nxt_s = {param_hi_r, word_byte_r};
              end else begin
                page_start_nxt_s = {param_hi_r, word_byte_r};
              end
            end
            3'd3: begin
              if (state_r == ST_CASET) begin
                col_end_nxt_s = {param_hi_r, word_byte_r};
              end else begin
                page_end_nxt_s = {param_hi_r, word_byte_r};
              end
            end
            default: param_hi_nxt_s = param_hi_r;
          endcase
        end
        ST_RAMWR: begin
          if (!lo_phase_r) begin
            hi_byte_nxt_s  = word_byte_r;
            lo_phase_nxt_s = 1'b1;
          end else begin
            lo_phase_nxt_s    = 1'b0;
            pixel_valid_nxt_s = 1'b1;
            pixel_x_nxt_s     = ptr_x_r;
            pixel_y_nxt_s     = ptr_y_r;
            pixel_data_nxt_s  = {hi_byte_r, word_byte_r};
            if (ptr_x_r == col_end_r) begin
              ptr_x_nxt_s = col_start_r;
              if (ptr_y_r == page_end_r) begin
                ptr_y_nxt_s = page_start_r;
              end else begin
                ptr_y_nxt_s = ptr_y_r + 9'd1;
              end
            end else begin
              ptr_x_nxt_s = ptr_x_r + 9'd1;
            end
          end
        end
        default: begin
          param_valid_nxt_s = 1'b1;
          param_byte_nxt_s  = word_byte_r;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Decoder state and registered outputs
  always_ff @(posedge clk) begin
    if (clear_s) begin
      state_r       <= ST_IDLE;
      param_cnt_r   <= 3'd0;
      param_hi_r    <= 1'b0;
      col_start_r   <= 9'd0;
      col_end_r     <= COL_END_RST;
      page_start_r  <= 9'd0;
      page_end_r    <= PAGE_END_RST;
      ptr_x_r       <= 9'd0;
      ptr_y_r       <= 9'd0;
      lo_phase_r    <= 1'b0;
      hi_byte_r     <= 8'd0;
      cmd_valid_r   <= 1'b0;
      cmd_byte_r    <= 8'd0;
      param_valid_r <= 1'b0;
      param_byte_r  <= 8'd0;
      pixel_valid_r <= 1'b0;
      pixel_x_r     <= 9'd0;
      pixel_y_r     <= 9'd0;
      pixel_data_r  <= 16'd0;
      sleep_r       <= 1'b0;
      disp_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      param_cnt_r   <= param_cnt_nxt_s;
      param_hi_r    <= param_hi_nxt_s;
      col_start_r   <= col_start_nxt_s;
      col_end_r     <= col_end_nxt_s;
      page_start_r  <= page_start_nxt_s;
      page_end_r    <= page_end_nxt_s;
      ptr_x_r       <= ptr_x_nxt_s;
      ptr_y_r       <= ptr_y_nxt_s;
      lo_phase_r    <= lo_phase_nxt_s;
      hi_byte_r     <= hi_byte_nxt_s;
      cmd_valid_r   <= cmd_valid_nxt_s;
      cmd_byte_r    <= cmd_byte_nxt_s;
      param_valid_r <= param_valid_nxt_s;
      param_byte_r  <= param_byte_nxt_s;
      pixel_valid_r <= pixel_valid_nxt_s;
      pixel_x_r     <= pixel_x_nxt_s;
      pixel_y_r     <= pixel_y_nxt_s;
      pixel_data_r  <= pixel_data_nxt_s;
      sleep_r       <= sleep_nxt_s;
      disp_r        <= disp_nxt_s;
    end
  end

  assign cmd_valid   = cmd_valid_r;
  assign cmd_byte    = cmd_byte_r;
  assign param_valid = param_valid_r;
  assign param_byte  = param_byte_r;
  assign pixel_valid = pixel_valid_r;
  assign pixel_x     = pixel_x_r;
  assign pixel_y     = pixel_y_r;
  assign pixel_data  = pixel_data_r;
  assign sleep_out   = sleep_r;
  assign display_on  = disp_r;

endmodule

// File: tb/tb_tft_ili9341_rx.sv
// Randomized scoreboard bench for tft_ili9341_rx: an SPI driver feeds the DUT and a
// byte-level reference model; a monitor pops expected events as the DUT pulses.
module tb_tft_ili9341_rx;

  logic        clk = 1'b0;
  logic        reset, tft_sck, tft_sdi, tft_dc, tft_cs, tft_reset;
  logic        cmd_valid, param_valid, pixel_valid, sleep_out, display_on;
  logic [7:0]  cmd_byte, param_byte;
  logic [8:0]  pixel_x, pixel_y;
  logic [15:0] pixel_data;

  always #5 clk = ~clk;

  tft_ili9341_rx #(.WIDTH(320), .HEIGHT(240)) dut (
    .clk(clk), .reset(reset), .tft_sck(tft_sck), .tft_sdi(tft_sdi), .tft_dc(tft_dc),
    .tft_cs(tft_cs), .tft_reset(tft_reset), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .param_valid(param_valid), .param_byte(param_byte), .pixel_valid(pixel_valid),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_data(pixel_data),
    .sleep_out(sleep_out), .display_on(display_on)
  );

  typedef struct {int kind; int a; int b; int c;} exp_t;  // kind: 0 cmd, 1 param, 2 pixel
  exp_t expq[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;

  // Reference model: window, pointer, pending high byte and the parameters seen so far
  int m_mode;  // 0 none/skip, 1 column window, 2 page window, 3 memory write
  int m_cs, m_ce, m_ps, m_pe, m_px, m_py, m_hi, m_have_hi, m_sleep, m_disp;
  int m_plist[$];
  bit ramwr_ok;

  logic [8:0] init_seq [64] = '{
    9'h001,
    9'h0CB, 9'h139, 9'h12C, 9'h100, 9'h134, 9'h102,
    9'h0CF, 9'h100, 9'h1C1, 9'h130,
    9'h0E8, 9'h185, 9'h100, 9'h178,
    9'h0EA, 9'h100, 9'h100,
    9'h0ED, 9'h164, 9'h103, 9'h112, 9'h181,
    9'h0F7, 9'h120,
    9'h0C0, 9'h123,
    9'h0C1, 9'h110,
    9'h0C5, 9'h13E, 9'h128,
    9'h0C7, 9'h186,
    9'h036, 9'h148,
    9'h03A, 9'h155,
    9'h0B1, 9'h100, 9'h118,
    9'h0B6, 9'h108, 9'h182, 9'h127,
    9'h0F2, 9'h100,
    9'h026, 9'h101,
    9'h02A, 9'h100, 9'h100, 9'h101, 9'h13F,
    9'h02B, 9'h100, 9'h100, 9'h100, 9'h1EF,
    9'h011, 9'h029, 9'h013, 9'h038, 9'h02C
  };

  logic [7:0] other_cmds [11] = '{8'h36, 8'h3A, 8'hB1, 8'hC0, 8'h10, 8'h11,
                                  8'h28, 8'h29, 8'h13, 8'h00, 8'hFF};

  task automatic m_reset();
    m_mode = 0; m_cs = 0; m_ce = 319; m_ps = 0; m_pe = 239;
    m_px = 0; m_py = 0; m_have_hi = 0; m_hi = 0; m_sleep = 0; m_disp = 0;
    m_plist.delete();
    ramwr_ok = 1'b0;
  endtask

  // Pointer as a linear index into the window, row-major, wrapping at the window size
  task automatic m_advance();
    int w, h, idx;
    w = m_ce - m_cs + 1;
    h = m_pe - m_ps + 1;
    idx = ((m_py - m_ps) * w + (m_px - m_cs) + 1) % (w * h);
    m_px = m_cs + idx % w;
    m_py = m_ps + idx / w;
  endtask

  task automatic m_word(input bit dc, input logic [7:0] b);
    int v;
    if (!dc) begin
      expq.push_back('{0, int'(b), 0, 0});
      m_plist.delete();
      m_have_hi = 0;
      case (b)
        8'h01: m_reset();
        8'h2A: m_mode = 1;
        8'h2B: m_mode = 2;
        8'h2C: begin m_mode = 3; m_px = m_cs; m_py = m_ps; end
        8'h3C: m_mode = 3;
        8'h11: begin m_sleep = 1; m_mode = 0; end
        8'h10: begin m_sleep = 0; m_mode = 0; end
        8'h29: begin m_disp = 1; m_mode = 0; end
        8'h28: begin m_disp = 0; m_mode = 0; end
        default: m_mode = 0;
      endcase
    end else if (m_mode == 3) begin
      if (m_have_hi == 0) begin
        m_hi = int'(b);
        m_have_hi = 1;
      end else begin
        expq.push_back('{2, m_px, m_py, m_hi * 256 + int'(b)});
        m_have_hi = 0;
        m_advance();
      end
    end else begin
      expq.push_back('{1, int'(b), 0, 0});
      if (m_mode == 1 || m_mode == 2) begin
        m_plist.push_back(int'(b));
        if (m_plist.size() == 2 || m_plist.size() == 4) begin
          v = (m_plist[m_plist.size() - 2] * 256 + m_plist[m_plist.size() - 1]) % 512;
          if (m_mode == 1 && m_plist.size() == 2) m_cs = v;
          else if (m_mode == 1) m_ce = v;
          else if (m_plist.size() == 2) m_ps = v;
          else m_pe = v;
        end
      end
    end
  endtask

  // SPI mode 0 master, four system clocks per sck period
  task automatic spi_bits(input bit dc, input logic [7:0] b, input int n);
    tft_cs = 1'b0;
    for (int i = 7; i > 7 - n; i--) begin
      tft_sdi = b[i];
      tft_dc  = dc;
      #20 tft_sck = 1'b1;
      #20 tft_sck = 1'b0;
    end
  endtask

  task automatic send(input bit dc, input logic [7:0] b);
    spi_bits(dc, b, 8);
    m_word(dc, b);
  endtask

  task automatic check_flags(input string tag);
    total++;
    if (sleep_out !== (m_sleep != 0) || display_on !== (m_disp != 0)) begin
      bad++;
      $display("FAIL flags(%s): sleep_out=%0b display_on=%0b expected %0d %0d",
               tag, sleep_out, display_on, m_sleep, m_disp);
    end
  endtask

  task automatic cmd(input logic [7:0] b);
    send(1'b0, b);
    repeat (3) @(negedge clk);
    check_flags($sformatf("cmd %02h", b));
  endtask

  task automatic put(input logic [8:0] w);
    if (w[8]) send(1'b1, w[7:0]);
    else cmd(w[7:0]);
  endtask

  task automatic pixel(input logic [15:0] v);
    send(1'b1, v[15:8]);
    send(1'b1, v[7:0]);
  endtask

  task automatic partial(input logic [7:0] b, input int n);
    spi_bits(1'b0, b, n);
    tft_cs = 1'b1;
    #40 tft_cs = 1'b0;
  endtask

  task automatic set_window(input logic [7:0] c);
    int s, e;
    s = $urandom_range(0, 300);
    e = s + $urandom_range(0, 5);
    cmd(c);
    send(1'b1, 8'(s >> 8)); send(1'b1, 8'(s));
    send(1'b1, 8'(e >> 8)); send(1'b1, 8'(e));
    ramwr_ok = 1'b0;
  endtask

  task automatic check_zero(input string tag, input int act);
    total++;
    if (act != 0) begin
      bad++;
      $display("FAIL %s: got %0d expected 0", tag, act);
    end
  endtask

  // Monitor: every output pulse must match the oldest expected event
  always @(negedge clk) begin
    if (!reset && (cmd_valid || param_valid || pixel_valid)) begin
      total++;
      if (int'(cmd_valid) + int'(param_valid) + int'(pixel_valid) > 1) begin
        bad++;
        $display("FAIL multi_pulse: cmd=%0b param=%0b pixel=%0b expected one",
                 cmd_valid, param_valid, pixel_valid);
      end else if (expq.size() == 0) begin
        bad++;
        $display("FAIL unexpected: cmd=%0b/%02h param=%0b/%02h pixel=%0b expected none",
                 cmd_valid, cmd_byte, param_valid, param_byte, pixel_valid);
      end else begin
        mon_e = expq.pop_front();
        if (cmd_valid && (mon_e.kind != 0 || int'(cmd_byte) != mon_e.a)) begin
          bad++;
          $display("FAIL cmd: got %02h expected kind %0d value %02h", cmd_byte, mon_e.kind, mon_e.a);
        end else if (param_valid && (mon_e.kind != 1 || int'(param_byte) != mon_e.a)) begin
          bad++;
          $display("FAIL param: got %02h expected kind %0d value %02h", param_byte, mon_e.kind, mon_e.a);
        end else if (pixel_valid && (mon_e.kind != 2 || int'(pixel_x) != mon_e.a ||
                     int'(pixel_y) != mon_e.b || int'(pixel_data) != mon_e.c)) begin
          bad++;
          $display("FAIL pixel: got (%0d,%0d)=%04h expected kind %0d (%0d,%0d)=%04h",
                   pixel_x, pixel_y, pixel_data, mon_e.kind, mon_e.a, mon_e.b, mon_e.c);
        end
      end
    end
  end

  initial begin
    int act, n;
    reset = 1'b1; tft_reset = 1'b1; tft_cs = 1'b1; tft_sck = 1'b0;
    tft_sdi = 1'b0; tft_dc = 1'b0;
    m_reset();
    repeat (5) @(negedge clk);
    check_zero("reset_cmd_byte", int'(cmd_byte));
    check_zero("reset_pulses", int'(cmd_valid) + int'(param_valid) + int'(pixel_valid));
    check_flags("reset");
    reset = 1'b0;
    repeat (4) @(negedge clk);

    cmd(8'h29);

    cmd(8'h2A); send(1'b1, 8'h00); send(1'b1, 8'h0A); send(1'b1, 8'h00); send(1'b1, 8'h0C);
    cmd(8'h2B); send(1'b1, 8'h00); send(1'b1, 8'h05); send(1'b1, 8'h00); send(1'b1, 8'h06);
    cmd(8'h2C);
    for (int i = 0; i < 7; i++) pixel(16'h1234 + 16'(i));

    send(1'b1, 8'hAB);
    cmd(8'h3C);
    pixel(16'hF800);

    partial(8'hFF, 5);
    cmd(8'h11);

    cmd(8'h2C);
    pixel(16'h0F0F);
    send(1'b1, 8'h77);
    repeat (4) @(negedge clk);
    tft_reset = 1'b0;
    repeat (10) @(negedge clk);
    m_reset();
    check_flags("panel_reset");
    check_zero("rst_cmd_byte", int'(cmd_byte));
    check_zero("rst_param_byte", int'(param_byte));
    check_zero("rst_pixel_x", int'(pixel_x));
    check_zero("rst_pixel_y", int'(pixel_y));
    check_zero("rst_pixel_data", int'(pixel_data));
    tft_reset = 1'b1;
    repeat (4) @(negedge clk);
    send(1'b1, 8'h55); send(1'b1, 8'h66);
    cmd(8'h2A); send(1'b1, 8'h01); send(1'b1, 8'h3E);
    cmd(8'h2B); send(1'b1, 8'h00); send(1'b1, 8'hEE);
    cmd(8'h2C);
    for (int i = 0; i < 5; i++) pixel(16'hA000 + 16'(i));

    for (int i = 0; i < 64; i++) put(init_seq[i]);
    pixel(16'hABCD);

    for (int it = 0; it < 40; it++) begin
      act = $urandom_range(0, 5);
      case (act)
        0: begin
          cmd(other_cmds[$urandom_range(0, 10)]);
          n = $urandom_range(0, 3);
          repeat (n) send(1'b1, 8'($urandom));
        end
        1: set_window(8'h2A);
        2: set_window(8'h2B);
        3: begin
          cmd(8'h2C);
          ramwr_ok = 1'b1;
          n = $urandom_range(1, 8);
          repeat (n) pixel(16'($urandom));
        end
        4: begin
          if (ramwr_ok) begin
            cmd(8'h3C);
            n = $urandom_range(1, 4);
            repeat (n) pixel(16'($urandom));
          end else begin
            cmd(8'h00);
          end
        end
        default: partial(8'($urandom), $urandom_range(1, 7));
      endcase
    end

    repeat (20) @(negedge clk);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL leftover: %0d expected events never seen, expected 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tft_ili9341_rx.md
Name: tft_ili9341_rx

Overview:
- Receive-side model of the ILI9341 4-wire SPI link: the display end of the interface our TFT driver transmits on.
- Oversamples tft_sck/tft_sdi/tft_dc/tft_cs on the system clock and assembles 9-bit words (dc + 8 data bits).
- Decodes the command set the driver emits, tracks the CASET/PASET window, and converts RAMWR byte pairs into addressed RGB565 pixel writes.
- Used as a bench display model and as an on-chip loopback/frame-capture front end.

Parameters:
- WIDTH, 320, default column count; reset value of col_end = WIDTH-1.
- HEIGHT, 240, default page count; reset value of page_end = HEIGHT-1.

Ports:
- clk  in  1  system clock; must be at least 4x tft_sck frequency.
- reset  in  1  synchronous, active-high.
- tft_sck  in  1  SPI clock; idle low, data sampled on rising edge.
- tft_sdi  in  1  SPI data, MSB first.
- tft_dc  in  1  0 = command byte, 1 = data byte; sampled together with bit 0.
- tft_cs  in  1  chip select, active low.
- tft_reset  in  1  panel reset, active low.
- cmd_valid  out  1  one-cycle pulse: command byte received.
- cmd_byte  out  8  last command byte.
- param_valid  out  1  one-cycle pulse: data byte received outside RAMWR/RAMWRC.
- param_byte  out  8  last data byte.
- pixel_valid  out  1  one-cycle pulse: pixel completed.
- pixel_x  out  9  column of the completed pixel.
- pixel_y  out  9  page of the completed pixel.
- pixel_data  out  16  RGB565 value, first byte in [15:8].
- sleep_out  out  1  1 after 0x11, 0 after 0x10 or any reset.
- display_on  out  1  1 after 0x29, 0 after 0x28 or any reset.

Behaviour:
- Input sync: each of sck, sdi, dc and cs passes through a 2-flop synchronizer. A rising edge is detected when synced sck is 1 and its previous value was 0.
- Shift: on each detected edge with synced cs=0, shift sdi into an 8-bit register and increment a 3-bit bit counter.
  - On the 8th edge, latch {dc, byte}, clear the counter, and raise the appropriate pulse on the next clk.
  - Latency: 4 clk cycles max from the raw 8th sck rise to the pulse.
- cs high: clears the bit counter, discarding any partial byte. Command state and window are retained.
- Reset conditions: reset=1 or synced tft_reset=0 clears all state.
  - All pulses 0; cmd_byte, param_byte, pixel_data and pixel_x/y = 0; sleep_out = display_on = 0.
  - Window reset values: col_start = 0, col_end = WIDTH-1, page_start = 0, page_end = HEIGHT-1.
  - Decoder state goes to IDLE.
- Software reset: command 0x01 has the same effect as a reset, except that cmd_valid still pulses.
- Decoder states: IDLE, CASET, PASET, RAMWR, SKIP.
  - Any command byte (dc=0) pulses cmd_valid and selects the next state from any state, aborting the current command:
    - 0x2A -> CASET, param index 0.
    - 0x2B -> PASET, param index 0.
    - 0x2C -> RAMWR; pointer set to (col_start, page_start); byte phase set to high.
    - 0x3C -> RAMWR; pointer kept; byte phase set to high.
    - 0x11/0x10/0x29/0x28 update the flags, then -> SKIP.
    - All other commands -> SKIP.
  - CASET/PASET: params 0-3 form {SH, SL, EH, EL}.
    - The start value is committed after param 1 and the end value after param 3, each taking the low 9 bits of the 16-bit value.
    - Further data bytes pulse param_valid only.
    - start > end is stored as given; the pointer wrap rules below still apply.
  - RAMWR, high phase: store the byte, switch to low phase. No pulse.
  - RAMWR, low phase: pulse pixel_valid with the current pointer and {hi, lo}, then advance the pointer:
    - x == col_end: x <= col_start, y <= page_start if y == page_end, otherwise y+1.
    - Otherwise: x+1.
  - IDLE/SKIP data bytes: pulse param_valid.
- Outputs are registered. A new command byte arriving in the same cycle a pixel completes cannot occur, since bytes are at least 8 sck periods apart.

Test Plan:
- Reset, then send command 0x29 (dc=0) -> one cmd_valid with cmd_byte=0x29; display_on=1; no param_valid.
- Send 0x2A, 00,0A,00,0C, then 0x2B, 00,05,00,06, 0x2C, and 6 pixels 0x1234.. -> pixels at (10,5),(11,5),(12,5),(10,6),(11,6),(12,6); 7th pixel at (10,5).
- During RAMWR send one data byte 0xAB, then command 0x3C and pixel 0xF800 -> the partial byte is dropped; the pixel lands at the pointer following the last complete pixel with data 0xF800.
- Raise cs after 5 bits, then send a full 0x11 -> exactly one cmd_valid with 0x11; sleep_out=1.
- Pull tft_reset low for 10 clk mid-RAMWR -> all flags and outputs 0; window restored to 0..319 x 0..239; following data bytes give param_valid, not pixels.
- Run the driver's 64-byte init sequence plus 2 pixel bytes at clk/sck = 4 -> every command and param byte is reproduced in order; one pixel at (0,0).
